// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing the single-read-port program ROM between
// instruction fetch (IF) and load/store (LS), with one-cycle-late response routing.
module rom_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_if_req,
    input  logic [ADDR_WIDTH-1:0] i_if_addr,
    output logic                  o_if_gnt,
    output logic                  o_if_rvalid,
    output logic [DATA_WIDTH-1:0] o_if_rdata,
    input  logic                  i_ls_req,
    input  logic [ADDR_WIDTH-1:0] i_ls_addr,
    output logic                  o_ls_gnt,
    output logic                  o_ls_rvalid,
    output logic [DATA_WIDTH-1:0] o_ls_rdata,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    input  logic [DATA_WIDTH-1:0] i_rom_rdata
);

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

    logic last_gnt;
    logic rsp_valid;
    logic rsp_owner;

    // On a tie the port that did not win last time gets the ROM.
    always_comb begin
        o_if_gnt = 1'b0;
        o_ls_gnt = 1'b0;
        if (!i_rst) begin
            if (i_if_req && i_ls_req) begin
                if (last_gnt == PORT_LS) begin
                    o_if_gnt = 1'b1;
                end else begin
                    o_ls_gnt = 1'b1;
                end
            end else begin
                o_if_gnt = i_if_req;
                o_ls_gnt = i_ls_req;
            end
        end
    end

    assign o_rom_addr = o_if_gnt ? i_if_addr :
                        o_ls_gnt ? i_ls_addr : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_gnt  <= PORT_LS;
            rsp_valid <= 1'b0;
            rsp_owner <= PORT_IF;
        end else if (o_if_gnt || o_ls_gnt) begin
            last_gnt  <= o_ls_gnt;
            rsp_valid <= 1'b1;
            rsp_owner <= o_ls_gnt;
        end else begin
            rsp_valid <= 1'b0;
        end
    end

    // The tag is registered, so a response still lands in the first reset cycle.
    assign o_if_rvalid = rsp_valid && (rsp_owner == PORT_IF);
    assign o_ls_rvalid = rsp_valid && (rsp_owner == PORT_LS);
    assign o_if_rdata  = o_if_rvalid ? i_rom_rdata : '0;
    assign o_ls_rdata  = o_ls_rvalid ? i_rom_rdata : '0;

endmodule
